// File: rtl/cache_arbiter.sv
// Round-robin arbiter from NUM_CORES cores to one cache port. Grant comes 1 cycle after req_valid, and rsp_done comes 1 cycle after cache_ack.
// No backpressure: a core holds req_valid until its rsp_done, and a watchdog aborts a transaction the cache never acknowledges.
module cache_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CORES-1:0]        req_valid_i,
  input  logic [NUM_CORES-1:0]        req_rw_i,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata_i,
  output logic [NUM_CORES-1:0]        gnt_o,
  output logic [NUM_CORES-1:0]        rsp_done_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_hit_o,
  output logic                        rsp_err_o,
  output logic                        cache_req_o,
  output logic                        cache_rw_o,
  output logic [ADDR_W-1:0]           cache_addr_o,
  output logic [DATA_W-1:0]           cache_wdata_o,
  input  logic                        cache_ack_i,
  input  logic [DATA_W-1:0]           cache_rdata_i,
  input  logic                        cache_hit_i
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [WD_W-1:0]        wdog_q;
  logic [NUM_CORES-1:0]   gnt_q;
  logic [NUM_CORES-1:0]   rsp_done_q;
  logic [DATA_W-1:0]      rsp_rdata_q;
  logic                   rsp_hit_q;
  logic                   rsp_err_q;
  logic                   cache_req_q;
  logic                   cache_rw_q;
  logic [ADDR_W-1:0]      cache_addr_q;
  logic [DATA_W-1:0]      cache_wdata_q;

  logic                   win_found_d;
  logic [PTR_W-1:0]       win_idx_d;
  logic [NUM_CORES-1:0]   win_oh_d;
  logic [PTR_W-1:0]       ptr_d;

  // Search starts at ptr_q and wraps, so the last winner has lowest priority.
  always_comb begin
    int j;
    j           = 0;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    win_oh_d    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!win_found_d && req_valid_i[j]) begin
        win_found_d = 1'b1;
        win_idx_d   = PTR_W'(j);
      end
    end
    win_oh_d[win_idx_d] = win_found_d;
    ptr_d = (win_idx_d == PTR_W'(NUM_CORES - 1)) ? '0 : win_idx_d + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      wdog_q        <= '0;
      gnt_q         <= '0;
      rsp_done_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
      cache_req_q   <= 1'b0;
      cache_rw_q    <= 1'b0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            gnt_q         <= win_oh_d;
            cache_req_q   <= 1'b1;
            cache_rw_q    <= req_rw_i[win_idx_d];
            cache_addr_q  <= req_addr_i[win_idx_d*ADDR_W +: ADDR_W];
            cache_wdata_q <= req_wdata_i[win_idx_d*DATA_W +: DATA_W];
            ptr_q         <= ptr_d;
            wdog_q        <= '0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the final watchdog cycle still completes normally.
          if (cache_ack_i) begin
            cache_req_q <= 1'b0;
            rsp_done_q  <= gnt_q;
            rsp_hit_q   <= cache_hit_i;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= cache_rw_q ? cache_rdata_i : '0;
            state_q     <= DONE;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            cache_req_q <= 1'b0;
            rsp_done_q  <= gnt_q;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= DONE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        DONE: begin
          gnt_q      <= '0;
          rsp_done_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign rsp_done_o    = rsp_done_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_hit_o     = rsp_hit_q;
  assign rsp_err_o     = rsp_err_q;
  assign cache_req_o   = cache_req_q;
  assign cache_rw_o    = cache_rw_q;
  assign cache_addr_o  = cache_addr_q;
  assign cache_wdata_o = cache_wdata_q;

endmodule
